// File: rtl/veririsc_controller.sv
// VeriRISC sequencing controller: eight-phase instruction cycle producing memory
// enables and IR/PC/accumulator strobes from the current phase, opcode and zero flag.
module veririsc_controller #(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       load_ir,
  output logic       load_ac,
  output logic       load_pc,
  output logic       inc_pc,
  output logic       halt,
  output logic [2:0] phase
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  state_t state;
  state_t next_state;
  logic   is_aluop;

  assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= INST_ADDR;
    else       state <= next_state;
  end

  // Encodings 9..15 fall into the default arm and recover to INST_ADDR.
  always_comb begin
    next_state = INST_ADDR;
    unique case (state)
      INST_ADDR:  next_state = INST_FETCH;
      INST_FETCH: next_state = INST_LOAD;
      INST_LOAD:  next_state = IDLE;
      IDLE:       next_state = OP_ADDR;
      OP_ADDR:    next_state = (HALT_STICKY && (opcode == OP_HLT)) ? HALTED : OP_FETCH;
      OP_FETCH:   next_state = ALU_OP;
      ALU_OP:     next_state = STORE;
      STORE:      next_state = INST_ADDR;
      HALTED:     next_state = HALTED;
      default:    next_state = INST_ADDR;
    endcase
  end

  // opcode/zero are only looked at in phases 4..7, so unknowns elsewhere stay out.
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    inc_pc  = 1'b0;
    halt    = 1'b0;
    unique case (state)
      INST_ADDR: ;
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (opcode == OP_HLT);
      end
      OP_FETCH: mem_rd = is_aluop;
      ALU_OP: begin
        mem_rd  = is_aluop;
        load_ac = is_aluop;
        inc_pc  = (opcode == OP_SKZ) && zero;
        load_pc = (opcode == OP_JMP);
      end
      STORE: begin
        mem_rd  = is_aluop;
        load_ac = is_aluop;
        inc_pc  = (opcode == OP_JMP);
        load_pc = (opcode == OP_JMP);
        mem_wr  = (opcode == OP_STO);
      end
      HALTED: halt = 1'b1;
      default: ;
    endcase
  end

  assign phase = (state == HALTED) ? 3'b111 : state[2:0];

  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_) !(mem_rd && mem_wr));
  a_halt_no_write:   assert property (@(posedge clk) disable iff (!rst_) halt |-> !mem_wr);
  a_state_known:     assert property (@(posedge clk) disable iff (!rst_) !$isunknown(state));

endmodule

// File: tb/tb_veririsc_controller.sv
// Scoreboard bench for veririsc_controller: stimulus pushes expected per-phase outputs,
// a monitor pops and compares them; one sticky-halt and one pulsed-halt instance.
module tb_veririsc_controller;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  logic       clk;
  logic       rst_;
  logic [2:0] opcode;
  logic       zero;

  logic       rd_a, wr_a, ir_a, ac_a, pc_a, inc_a, hlt_a;
  logic [2:0] phase_a;
  logic       rd_b, wr_b, ir_b, ac_b, pc_b, inc_b, hlt_b;
  logic [2:0] phase_b;

  logic [7:0] mem [32];

  typedef struct {
    int         kind;
    int         sel;
    logic [9:0] exp;
    bit         late;
    string      name;
  } entry_t;

  entry_t sb[$];
  int     vectors_applied = 0;
  int     miscompares = 0;

  veririsc_controller #(.HALT_STICKY(1'b1)) dut_a (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
    .mem_rd(rd_a), .mem_wr(wr_a), .load_ir(ir_a), .load_ac(ac_a),
    .load_pc(pc_a), .inc_pc(inc_a), .halt(hlt_a), .phase(phase_a)
  );

  veririsc_controller #(.HALT_STICKY(1'b0)) dut_b (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
    .mem_rd(rd_b), .mem_wr(wr_b), .load_ir(ir_b), .load_ac(ac_b),
    .load_pc(pc_b), .inc_pc(inc_b), .halt(hlt_b), .phase(phase_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the 32x8 memory: the store path always targets 5'h1F with 8'hA5.
  initial for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  always @(posedge clk) if (wr_a) mem[5'h1F] <= 8'hA5;

  // Expected {phase, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt}; ph 8 = HALTED.
  function automatic logic [9:0] model(input int ph, input logic [2:0] op, input logic z);
    logic rd, wr, ir, ac, ld, inc, hl;
    logic alu;
    logic [2:0] p;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    {rd, wr, ir, ac, ld, inc, hl} = 7'b0;
    p = ph[2:0];
    case (ph)
      1: rd = 1'b1;
      2, 3: begin rd = 1'b1; ir = 1'b1; end
      4: begin inc = 1'b1; hl = (op == HLT); end
      5: rd = alu;
      6: begin rd = alu; ac = alu; inc = (op == SKZ) && z; ld = (op == JMP); end
      7: begin rd = alu; ac = alu; inc = (op == JMP); ld = (op == JMP); wr = (op == STO); end
      8: begin p = 3'b111; hl = 1'b1; end
      default: ;
    endcase
    return {p, rd, wr, ir, ac, ld, inc, hl};
  endfunction

  task automatic checkOutput(input entry_t e);
    logic [9:0] act;
    if (e.kind == 1)      act = {2'b00, mem[5'h1F]};
    else if (e.sel == 0)  act = {phase_a, rd_a, wr_a, ir_a, ac_a, pc_a, inc_a, hlt_a};
    else                  act = {phase_b, rd_b, wr_b, ir_b, ac_b, pc_b, inc_b, hlt_b};
    vectors_applied++;
    if (act !== e.exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b required %b at %0t", e.name, act, e.exp, $time);
    end
  endtask

  // Monitor: regular entries at the falling edge, late entries 3 time units after it.
  always begin
    @(negedge clk);
    while (sb.size() > 0 && !sb[0].late) checkOutput(sb.pop_front());
    #3;
    while (sb.size() > 0 && sb[0].late) checkOutput(sb.pop_front());
  end

  task automatic push_out(input int sel, input logic [9:0] exp, input string name, input bit late = 1'b0);
    entry_t e;
    e.kind = 0; e.sel = sel; e.exp = exp; e.late = late; e.name = name;
    sb.push_back(e);
  endtask

  task automatic push_mem(input logic [7:0] value, input string name);
    entry_t e;
    e.kind = 1; e.sel = 0; e.exp = {2'b00, value}; e.late = 1'b0; e.name = name;
    sb.push_back(e);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int sel, input logic [2:0] op, input logic z,
                               input int first_ph, input int last_ph, input string name);
    for (int ph = first_ph; ph <= last_ph; ph++) begin
      opcode = op;
      zero   = z;
      push_out(sel, model(ph, op, z), $sformatf("%s ph%0d", name, ph));
      advance();
    end
  endtask

  task automatic reset_for(input int n);
    rst_ = 1'b0;
    for (int i = 0; i < n; i++) begin
      push_out(0, 10'b0, $sformatf("reset cycle %0d", i));
      advance();
    end
    rst_ = 1'b1;
  endtask

  initial begin
    rst_   = 1'b0;
    opcode = ADD;
    zero   = 1'b0;
    advance();

    reset_for(3);
    applyStimulus(0, ADD, 1'b0, 0, 7, "ADD");

    push_mem(8'h00, "mem before STO");
    applyStimulus(0, STO, 1'b0, 0, 7, "STO");
    push_mem(8'hA5, "mem after STO");

    applyStimulus(0, SKZ, 1'b1, 0, 7, "SKZ z1");
    applyStimulus(0, SKZ, 1'b0, 0, 7, "SKZ z0");
    applyStimulus(0, JMP, 1'b1, 0, 7, "JMP");
    applyStimulus(0, AND, 1'b0, 0, 7, "AND");
    applyStimulus(0, XOR, 1'b1, 0, 7, "XOR");
    applyStimulus(0, LDA, 1'b0, 0, 7, "LDA");

    applyStimulus(1, HLT, 1'b0, 0, 7, "HLT pulsed");
    reset_for(2);

    applyStimulus(0, HLT, 1'b0, 0, 4, "HLT sticky");
    for (int i = 0; i < 20; i++) begin
      push_out(0, model(8, HLT, 1'b0), $sformatf("halted %0d", i));
      advance();
    end
    reset_for(1);
    applyStimulus(0, ADD, 1'b1, 0, 7, "ADD after halt");

    // Drop reset between edges during STORE; outputs must clear with no clock edge.
    applyStimulus(0, STO, 1'b0, 0, 7 - 1, "STO async");
    opcode = STO;
    push_out(0, model(7, STO, 1'b0), "STO async ph7");
    @(negedge clk);
    #1;
    rst_ = 1'b0;
    push_out(0, 10'b0, "async reset mid STORE", 1'b1);
    advance();
    reset_for(1);
    applyStimulus(0, ADD, 1'b0, 0, 7, "ADD after async");

    advance();
    advance();
    if (sb.size() != 0) begin
      $display("[TB] FAIL scoreboard drain: got %0d entries left required 0", sb.size());
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/veririsc_controller.md
Name: veririsc_controller

Overview:
- Sequencing controller for the VeriRISC CPU; it sits directly upstream of the 32x8 program/data memory.
- Steps through an 8-phase instruction cycle and produces `mem_rd`/`mem_wr` for the memory, plus load/increment strobes for the IR, PC and accumulator.
- Decodes the 3-bit opcode and the accumulator zero flag.
- Guarantees that memory `read` and `write` are never asserted together.

Parameters:
- HALT_STICKY, 1, 1 = HLT parks the FSM in HALTED until reset; 0 = `halt` pulses in OP_ADDR and the cycle continues.

Ports:
- clk  input  1  rising-edge clock, shared with the memory
- rst_  input  1  asynchronous active-low reset
- opcode  input  3  instruction opcode from the IR: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
- zero  input  1  accumulator-is-zero flag
- mem_rd  output  1  memory read enable
- mem_wr  output  1  memory write enable
- load_ir  output  1  instruction register load
- load_ac  output  1  accumulator load
- load_pc  output  1  program counter load (jump)
- inc_pc  output  1  program counter increment
- halt  output  1  processor halted
- phase  output  3  current phase, for debug and bench sync; HALTED reads 3'b111 with `halt`=1

Behaviour:
- Reset and state register:
  - Reset is asynchronous, active-low, on `rst_`. It forces the state to INST_ADDR, so every output is 0 and `phase` is 0.
  - State advances only on posedge clk when `rst_` is high.
  - Release of `rst_` mid-cycle takes effect at the next edge from INST_ADDR.
  - Reset asserted in any state, including HALTED, returns to INST_ADDR immediately, with all strobes 0 in the same delta.
- Sequence: INST_ADDR(0) -> INST_FETCH(1) -> INST_LOAD(2) -> IDLE(3) -> OP_ADDR(4) -> OP_FETCH(5) -> ALU_OP(6) -> STORE(7) -> INST_ADDR. One state per clock; 8 clocks per instruction.
- HALTED state:
  - Entered from OP_ADDR when `opcode`==HLT and HALT_STICKY=1.
  - Exits only via reset.
  - Outputs: `halt`=1, all other strobes 0, `phase`=3'b111.
- Output decode: combinational from the state register plus `opcode`/`zero`. No added latency. Define ALUOP = `opcode` in {ADD, AND, XOR, LDA}.
  - INST_ADDR: all 0.
  - INST_FETCH: `mem_rd`=1.
  - INST_LOAD: `mem_rd`=1, `load_ir`=1.
  - IDLE: `mem_rd`=1, `load_ir`=1.
  - OP_ADDR: `inc_pc`=1; `halt`=(`opcode`==HLT).
  - OP_FETCH: `mem_rd`=ALUOP.
  - ALU_OP: `mem_rd`=ALUOP, `load_ac`=ALUOP, `inc_pc`=(`opcode`==SKZ && `zero`), `load_pc`=(`opcode`==JMP).
  - STORE: `mem_rd`=ALUOP, `load_ac`=ALUOP, `inc_pc`=(`opcode`==JMP), `load_pc`=(`opcode`==JMP), `mem_wr`=(`opcode`==STO).
- Memory timing: the memory registers its read data on the posedge where `read`=1. Data requested in INST_FETCH is therefore valid during INST_LOAD/IDLE, where `load_ir` captures it.
- Mutual exclusion:
  - `mem_wr` is asserted only in STORE with STO. STO is not ALUOP, so `mem_rd` is 0 there.
  - `mem_rd` && `mem_wr` is never true.
  - `load_pc` and `inc_pc` are both 1 only in STORE for JMP; the PC gives load priority.
- Unknowns:
  - X on `opcode`/`zero` outside states that decode them must not propagate to outputs; decode uses a unique case with default 0.
  - An illegal state encoding recovers to INST_ADDR on the next edge.
- Assertions required in RTL:
  - `mem_rd` && `mem_wr` never true.
  - `halt` implies no `mem_wr`.
  - State not X after reset release.

Test Plan:
- Reset: hold `rst_`=0 for 3 clks, release, `opcode`=ADD. Required: all outputs 0 during reset; `phase` sequence 0,1,2,3,4,5,6,7,0 on successive clocks; `mem_rd`=1 in phases 1,2,3,5,6,7; `load_ac`=1 in phases 6,7.
- STO: `opcode`=STO. Required: `mem_wr`=1 only in phase 7; `mem_rd`=0 in phases 5–7; with the memory attached, data at `addr` 5'h1F becomes 8'hA5 after the STORE edge.
- SKZ: `opcode`=SKZ with `zero`=1, then with `zero`=0. Required: `inc_pc`=1 in phase 6 only when `zero`=1; `inc_pc`=1 in phase 4 in both runs.
- JMP: `opcode`=JMP. Required: `load_pc`=1 in phases 6 and 7; `inc_pc`=1 in phases 4 and 7; `mem_rd`=0 in phases 5–7.
- HLT:
  - HALT_STICKY=1: `halt`=1 in phase 4, then `phase`=7 with `halt`=1 held for 20 clks and all strobes 0; `rst_` pulse returns `phase` to 0.
  - HALT_STICKY=0: `halt` pulses one clk and the cycle continues.
- Async reset mid-STORE with STO: drop `rst_` between edges. Required: `mem_wr` falls to 0 immediately, without waiting for clk, and `phase`=0.
